mem_bus_responder: RTL
======================

// Module: mem_bus_responder
// PURPOSE
// - Memory-side responder on the shared 32-bit interconnect bus driven by the cache/fetch initiators.
// - Accepts one granted request at a time and holds a byte-writable word store of 2**ADDR_W x 32 bits.
// - Returns read data on the tristate mem_data bus and pulses mem_data_valid once to complete each request.
// PARAMETERS
// - ADDR_W  14  word-index bits; store is 2**ADDR_W words; mem_addr[ADDR_W+1:2] indexes it, upper bits ignored (wrap)
// - RD_LAT  4   cycles from accept edge to read mem_data_valid cycle (>=1)
// - WR_LAT  2   cycles from accept edge to write mem_data_valid cycle (>=1)
// PORTS
// - clk             in     1   clock, all state on rising edge
// - reset           in     1   asynchronous, active-low reset
// - mem_en          in     1   an initiator owns the bus; address, req, rd_wr, size and write data are driven
// - mem_req         in     1   request present (level)
// - mem_rd_wr       in     1   1 = write, 0 = read
// - mem_addr        in     32  byte address
// - mem_wr_size     in     2   write bytes: 00=1, 01=2, 10=3, 11=4
// - mem_data        inout  32  write data in (right-justified) / read data out
// - mem_data_valid  out    1   one-cycle completion pulse (read data valid, or write committed)
// BEHAVIOUR
// - Reset: state IDLE, mem_data_valid=0, mem_data high-Z, latency counter 0; store contents not cleared.
// - Reset mid-transaction aborts it: no valid pulse; a write not yet committed is never committed.
// - FSM IDLE -> BUSY -> RESP -> IDLE.
//   - IDLE: accept on a rising edge with mem_en=1 & mem_req=1; latch addr, rd_wr, size, mem_data (write data);
//     load counter with LAT-1 (RD_LAT or WR_LAT by rd_wr); LAT=1 goes straight to RESP.
//   - BUSY: counter decrements each cycle; at 0 -> RESP. mem_en/mem_req/bus changes ignored (latched copy used).
//   - RESP: mem_data_valid=1 for exactly this cycle; then IDLE.
// - Latency: valid is high in the cycle beginning LAT edges after the accept edge (LAT=1 -> cycle immediately after).
// - Requests are never accepted in BUSY or RESP; a request still held high in the first IDLE cycle after RESP is
//   a new request (initiators drop mem_req on seeing mem_data_valid).
// - Read: whole aligned word at mem_addr[ADDR_W+1:2]; addr[1:0] ignored; read at the RESP edge,
//   driven on mem_data only while in RESP; high-Z in all other cycles and for writes.
// - Write: byte k of data (k=0..size) goes to byte lane addr[1:0]+k; lanes beyond 3 are dropped (no wrap into the
//   next word); other lanes unchanged. Committed on the edge entering RESP.
// - Read-after-write to the same word in the next transaction returns the updated bytes.
// STRUCTURE
// - Shared package: size encodings (SZ_1B..SZ_4B), RD/WR encoding, FSM state encoding.
// - Sub-module mem_word_array: 2**ADDR_W x 32 synchronous-write / combinational-read array with 4 byte enables.
// - Top: FSM, latency counter, request latches, byte-enable/lane-shift logic, tristate output drivers.
// TESTING
// - Reset low mid-BUSY of a 4B write to 0x40 -> no valid pulse, mem_data Z; later read of 0x40 returns old word.
// - 4B write 0xDEADBEEF @0x100, then read @0x100 -> valid exactly WR_LAT, then RD_LAT cycles after accept; data 0xDEADBEEF.
// - 1B write 0x55 @0x101 over 0x00000000, then read @0x100 -> 0x00005500; 2B write 0xAABB @0x103 -> only lane3=0xBB.
// - 3B write 0x112233 @0x201 over 0xFFFFFFFF, then read @0x200 -> 0x112233FF.
// - Request held across BUSY with mem_addr changed mid-flight -> one valid pulse, latched address used,
//   mem_data Z outside RESP; back-to-back reads 0x100 then 0x104 -> two pulses, each RD_LAT after its accept.
// - Read of 0x100 + 4*2**ADDR_W -> returns word 0x100 (index wraps).

Source files
------------

// File: rtl/mem_bus_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_responder_pkg
// Shared encodings for the memory-side bus responder: write-size codes,
// read/write direction code, FSM state encoding, and the byte-lane helpers
// used to place right-justified write data into the addressed lanes.
// ---------------------------------------------------------------------------
package mem_bus_responder_pkg;

  // Number of bytes written, as carried on mem_wr_size.
  typedef enum logic [1:0] {
    SZ_1B = 2'b00,
    SZ_2B = 2'b01,
    SZ_3B = 2'b10,
    SZ_4B = 2'b11
  } wr_size_e;

  // Direction as carried on mem_rd_wr.
  typedef enum logic {
    BUS_RD = 1'b0,
    BUS_WR = 1'b1
  } rw_e;

  // Responder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } fsm_state_e;

  // Byte enables for a write of 'size' bytes starting at lane 'off'.
  // The mask is built 8 bits wide so lanes pushed past lane 3 simply fall
  // off the top instead of wrapping into lane 0.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] mask;
    case (wr_size_e'(size))
      SZ_1B:   mask = 8'h01;
      SZ_2B:   mask = 8'h03;
      SZ_3B:   mask = 8'h07;
      SZ_4B:   mask = 8'h0F;
      default: mask = 8'h0F;
    endcase
    mask = mask << off;
    return mask[3:0];
  endfunction

  // Moves right-justified write data up to its starting lane; bytes that
  // would land above lane 3 are discarded by the 32-bit result.
  function automatic logic [31:0] lane_shift(input logic [31:0] data, input logic [1:0] off);
    return data << {off, 3'b000};
  endfunction

endpackage

// File: rtl/mem_bus_responder_array.sv
// ---------------------------------------------------------------------------
// mem_word_array
// Word store of 2**ADDR_W x 32 bits with per-byte write enables.
// Write is synchronous on the rising clock edge; read is combinational.
// Contents are never reset.
// Ports:
//   clk    in   clock
//   we     in   write strobe
//   be     in   4 byte-lane enables (bit k -> bits 8k+7:8k)
//   addr   in   word index (shared by read and write)
//   wdata  in   lane-aligned write data
//   rdata  out  word currently stored at addr
// ---------------------------------------------------------------------------
module mem_word_array #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_r [2**ADDR_W];

  // Byte-masked write of the selected word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_bus_responder.sv
// ---------------------------------------------------------------------------
// mem_bus_responder
// Memory-side responder on the shared 32-bit bus. Accepts one request at a
// time, completes it after a fixed read or write latency with a one-cycle
// mem_data_valid pulse, and drives read data onto the tristate mem_data bus
// only during that pulse.
// Ports:
//   clk             in     clock, rising edge
//   reset           in     asynchronous active-low reset
//   mem_en          in     an initiator owns the bus
//   mem_req         in     request present (level)
//   mem_rd_wr       in     1 = write, 0 = read
//   mem_addr        in     byte address (word index = mem_addr[ADDR_W+1:2])
//   mem_wr_size     in     bytes to write minus one
//   mem_data        inout  write data in (right-justified) / read data out
//   mem_data_valid  out    one-cycle completion pulse
// ---------------------------------------------------------------------------
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_req,
  input  logic        mem_rd_wr,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_wr_size,
  inout  wire  [31:0] mem_data,
  output logic        mem_data_valid
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

  fsm_state_e        state_r;
  fsm_state_e        state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;

  // Request copy latched at the accept edge.
  logic [ADDR_W-1:0] idx_r;
  logic [1:0]        off_r;
  logic              wr_r;
  logic [1:0]        size_r;
  logic [31:0]       wdata_r;

  // Registered response.
  logic              valid_r;
  logic              drive_r;
  logic [31:0]       rd_data_r;

  logic              accept_s;
  logic              enter_resp_s;
  logic              we_s;
  logic [CNT_W-1:0]  load_s;
  logic              eff_wr_s;
  logic [ADDR_W-1:0] eff_idx_s;
  logic [1:0]        eff_off_s;
  logic [1:0]        eff_size_s;
  logic [31:0]       eff_wdata_s;
  logic [3:0]        be_s;
  logic [31:0]       lane_data_s;
  logic [31:0]       rd_word_s;
  logic              unused_addr_s;

  // Address bits above the store are ignored so the index wraps.
  assign unused_addr_s = ^mem_addr[31:ADDR_W+2];

  assign accept_s = (state_r == ST_IDLE) && mem_en && mem_req;
  assign load_s   = (rw_e'(mem_rd_wr) == BUS_WR) ? WR_LOAD : RD_LOAD;

  // Request fields used this cycle: live bus in IDLE (so a latency of 1
  // can complete on the accept edge itself), latched copy otherwise.
  always_comb begin
    eff_wr_s    = wr_r;
    eff_idx_s   = idx_r;
    eff_off_s   = off_r;
    eff_size_s  = size_r;
    eff_wdata_s = wdata_r;
    if (state_r == ST_IDLE) begin
      eff_wr_s    = (rw_e'(mem_rd_wr) == BUS_WR);
      eff_idx_s   = mem_addr[ADDR_W+1:2];
      eff_off_s   = mem_addr[1:0];
      eff_size_s  = mem_wr_size;
      eff_wdata_s = mem_data;
    end else begin
      eff_wr_s    = wr_r;
      eff_idx_s   = idx_r;
      eff_off_s   = off_r;
      eff_size_s  = size_r;
      eff_wdata_s = wdata_r;
    end
  end

  // Next-state and latency counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          cnt_s   = load_s;
          state_s = (load_s == {CNT_W{1'b0}}) ? ST_RESP : ST_BUSY;
        end else begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_RESP;
        end else begin
          cnt_s   = cnt_r - CNT_W'(1);
          state_s = ST_BUSY;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // The edge entering RESP is where writes commit and reads sample.
  assign enter_resp_s = (state_s == ST_RESP);
  assign we_s         = enter_resp_s && eff_wr_s;
  assign be_s         = byte_en(eff_size_s, eff_off_s);
  assign lane_data_s  = lane_shift(eff_wdata_s, eff_off_s);

  mem_word_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (we_s),
    .be    (be_s),
    .addr  (eff_idx_s),
    .wdata (lane_data_s),
    .rdata (rd_word_s)
  );

  // FSM state and latency counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Request latches, loaded only at the accept edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r   <= {ADDR_W{1'b0}};
      off_r   <= 2'b00;
      wr_r    <= 1'b0;
      size_r  <= 2'b00;
      wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      idx_r   <= mem_addr[ADDR_W+1:2];
      off_r   <= mem_addr[1:0];
      wr_r    <= (rw_e'(mem_rd_wr) == BUS_WR);
      size_r  <= mem_wr_size;
      wdata_r <= mem_data;
    end
  end

  // Completion pulse, bus-drive enable and captured read word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r   <= 1'b0;
      drive_r   <= 1'b0;
      rd_data_r <= 32'h0000_0000;
    end else begin
      valid_r <= enter_resp_s;
      drive_r <= enter_resp_s && !eff_wr_s;
      if (enter_resp_s && !eff_wr_s) begin
        rd_data_r <= rd_word_s;
      end
    end
  end

  assign mem_data_valid = valid_r;
  assign mem_data       = drive_r ? rd_data_r : {32{1'bz}};

endmodule
